// File: rtl/parking_gate_ctrl.sv
// Single-lane parking gate: two-field password admission, tailgate stop, lockout
// after repeated failures, and free-space tracking shown on two 7-segment digits.
module parking_gate_ctrl #(
   parameter int CAPACITY    = 9,
   parameter int PASS_W      = 2,
   parameter int PASS1_KEY   = 1,
   parameter int PASS2_KEY   = 2,
   parameter int WAIT_CYCLES = 3,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              sensor_entrance,
   input  logic                              sensor_exit,
   input  logic                              car_leave,
   input  logic [PASS_W-1:0]                 pass1,
   input  logic [PASS_W-1:0]                 pass2,
   output logic                              green_led,
   output logic                              red_led,
   output logic                              gate_open,
   output logic                              full,
   output logic                              lockout,
   output logic [$clog2(CAPACITY+1)-1:0]     free_cnt,
   output logic [6:0]                        HEX_1,
   output logic [6:0]                        HEX_2
);

   localparam int FW = $clog2(CAPACITY + 1);
   localparam int WW = $clog2(WAIT_CYCLES + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   localparam logic [FW-1:0]     CAP_V      = FW'(CAPACITY);
   localparam logic [WW-1:0]     WAIT_LAST  = WW'(WAIT_CYCLES - 1);
   localparam logic [TW-1:0]     TRIES_LAST = TW'(MAX_TRIES - 1);
   localparam logic [LW-1:0]     LOCK_LAST  = LW'(LOCK_CYCLES - 1);
   localparam logic [PASS_W-1:0] KEY1       = PASS_W'(PASS1_KEY);
   localparam logic [PASS_W-1:0] KEY2       = PASS_W'(PASS2_KEY);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PASSWORD,
      RIGHT_PASS,
      WRONG_PASS,
      STOP,
      LOCKED
   } state_t;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   localparam logic [6:0] HEX1_RST = seg7(4'(CAPACITY / 10));
   localparam logic [6:0] HEX2_RST = seg7(4'(CAPACITY % 10));

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [TW-1:0] tries_q, tries_d;
   logic [LW-1:0] lock_q, lock_d;
   logic [FW-1:0] free_q, free_d;
   logic          green_q, green_d;
   logic          red_q, red_d;
   logic          gate_q, gate_d;
   logic          full_q, full_d;
   logic          lockout_q, lockout_d;
   logic [6:0]    hex1_q, hex1_d;
   logic [6:0]    hex2_q, hex2_d;

   logic          match;
   logic          lot_full;
   logic          take_space;
   logic [6:0]    cnt_ext;

   assign match    = (pass1 == KEY1) && (pass2 == KEY2);
   assign lot_full = (free_q == '0);

   // Next-state, occupancy and output decode; outputs are derived from the
   // next-state values so that every output comes straight out of a flop.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      tries_d    = tries_q;
      lock_d     = lock_q;
      free_d     = free_q;
      take_space = 1'b0;

      case (state_q)
         IDLE: begin
            if (sensor_entrance && !lot_full) begin
               state_d = WAIT_PASSWORD;
               wait_d  = '0;
            end
         end
         WAIT_PASSWORD, WRONG_PASS: begin
            if (wait_q == WAIT_LAST) begin
               wait_d = '0;
               if (match) begin
                  state_d = RIGHT_PASS;
                  tries_d = '0;
               end else if (tries_q == TRIES_LAST) begin
                  state_d = LOCKED;
                  tries_d = tries_q + 1'b1;
                  lock_d  = '0;
               end else begin
                  state_d = WRONG_PASS;
                  tries_d = tries_q + 1'b1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         RIGHT_PASS: begin
            if (sensor_exit) begin
               take_space = 1'b1;
               state_d    = sensor_entrance ? STOP : IDLE;
            end
         end
         STOP: begin
            if (lot_full) begin
               state_d = IDLE;
            end else if (match) begin
               state_d = RIGHT_PASS;
            end
         end
         LOCKED: begin
            if (lock_q == LOCK_LAST) begin
               state_d = IDLE;
               tries_d = '0;
               lock_d  = '0;
            end else begin
               lock_d = lock_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A departure on the same edge as an admission hands its space straight over.
      if (take_space && car_leave) begin
         free_d = free_q;
      end else if (car_leave && (free_q != CAP_V)) begin
         free_d = free_q + 1'b1;
      end else if (take_space && (free_q != '0)) begin
         free_d = free_q - 1'b1;
      end

      green_d   = (state_d == RIGHT_PASS);
      gate_d    = (state_d == RIGHT_PASS);
      red_d     = (state_d == WRONG_PASS) || (state_d == STOP) || (state_d == LOCKED);
      lockout_d = (state_d == LOCKED);
      full_d    = (free_d == '0);

      cnt_ext = 7'(free_d);
      hex1_d  = seg7(4'(cnt_ext / 7'd10));
      hex2_d  = seg7(4'(cnt_ext % 7'd10));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         tries_q   <= '0;
         lock_q    <= '0;
         free_q    <= CAP_V;
         green_q   <= 1'b0;
         red_q     <= 1'b0;
         gate_q    <= 1'b0;
         full_q    <= (CAPACITY == 0);
         lockout_q <= 1'b0;
         hex1_q    <= HEX1_RST;
         hex2_q    <= HEX2_RST;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         tries_q   <= tries_d;
         lock_q    <= lock_d;
         free_q    <= free_d;
         green_q   <= green_d;
         red_q     <= red_d;
         gate_q    <= gate_d;
         full_q    <= full_d;
         lockout_q <= lockout_d;
         hex1_q    <= hex1_d;
         hex2_q    <= hex2_d;
      end
   end

   assign green_led = green_q;
   assign red_led   = red_q;
   assign gate_open = gate_q;
   assign full      = full_q;
   assign lockout   = lockout_q;
   assign free_cnt  = free_q;
   assign HEX_1     = hex1_q;
   assign HEX_2     = hex2_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a default-parameter instance for the
// admission/lockout/tailgate paths and a CAPACITY=2 instance for saturation.
module tb_parking_gate_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   int         total = 0;
   int         bad = 0;

   logic       d_ent, d_exit, d_leave;
   logic [1:0] d_p1, d_p2;
   logic       d_green, d_red, d_gate, d_full, d_lock;
   logic [3:0] d_free;
   logic [6:0] d_hex1, d_hex2;

   logic       c_ent, c_exit, c_leave;
   logic [1:0] c_p1, c_p2;
   logic       c_green, c_red, c_gate, c_full, c_lock;
   logic [1:0] c_free;
   logic [6:0] c_hex1, c_hex2;

   always #5 clk = ~clk;

   parking_gate_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .sensor_entrance(d_ent), .sensor_exit(d_exit), .car_leave(d_leave),
      .pass1(d_p1), .pass2(d_p2),
      .green_led(d_green), .red_led(d_red), .gate_open(d_gate),
      .full(d_full), .lockout(d_lock), .free_cnt(d_free),
      .HEX_1(d_hex1), .HEX_2(d_hex2)
   );

   parking_gate_ctrl #(.CAPACITY(2)) dut_cap (
      .clk(clk), .reset_n(reset_n),
      .sensor_entrance(c_ent), .sensor_exit(c_exit), .car_leave(c_leave),
      .pass1(c_p1), .pass2(c_p2),
      .green_led(c_green), .red_led(c_red), .gate_open(c_gate),
      .full(c_full), .lockout(c_lock), .free_cnt(c_free),
      .HEX_1(c_hex1), .HEX_2(c_hex2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      total++; if (d_green !== 1'b0) begin bad++; $display("[TB] FAIL rst_green got=%0b exp=0", d_green); end
      total++; if (d_red !== 1'b0) begin bad++; $display("[TB] FAIL rst_red got=%0b exp=0", d_red); end
      total++; if (d_gate !== 1'b0) begin bad++; $display("[TB] FAIL rst_gate got=%0b exp=0", d_gate); end
      total++; if (d_lock !== 1'b0) begin bad++; $display("[TB] FAIL rst_lockout got=%0b exp=0", d_lock); end
      total++; if (d_full !== 1'b0) begin bad++; $display("[TB] FAIL rst_full got=%0b exp=0", d_full); end
      total++; if (d_free !== 4'd9) begin bad++; $display("[TB] FAIL rst_free got=%0d exp=9", d_free); end
      total++; if (d_hex1 !== 7'b1000000) begin bad++; $display("[TB] FAIL rst_hex1 got=%b exp=1000000", d_hex1); end
      total++; if (d_hex2 !== 7'b0010000) begin bad++; $display("[TB] FAIL rst_hex2 got=%b exp=0010000", d_hex2); end
      total++; if (c_free !== 2'd2) begin bad++; $display("[TB] FAIL rst_cap_free got=%0d exp=2", c_free); end
      total++; if (c_hex2 !== 7'b0100100) begin bad++; $display("[TB] FAIL rst_cap_hex2 got=%b exp=0100100", c_hex2); end
   endtask

   task automatic test_normal_entry();
      d_p1 = 2'd1; d_p2 = 2'd2; d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (d_green !== 1'b0) begin bad++; $display("[TB] FAIL wait_green_%0d got=%0b exp=0", i, d_green); end
         tick();
      end
      total++; if (d_green !== 1'b1) begin bad++; $display("[TB] FAIL right_green got=%0b exp=1", d_green); end
      total++; if (d_gate !== 1'b1) begin bad++; $display("[TB] FAIL right_gate got=%0b exp=1", d_gate); end
      d_exit = 1'b1;
      tick();
      d_exit = 1'b0;
      total++; if (d_gate !== 1'b0) begin bad++; $display("[TB] FAIL admit_gate got=%0b exp=0", d_gate); end
      total++; if (d_free !== 4'd8) begin bad++; $display("[TB] FAIL admit_free got=%0d exp=8", d_free); end
      total++; if (d_hex1 !== 7'b1000000) begin bad++; $display("[TB] FAIL admit_hex1 got=%b exp=1000000", d_hex1); end
      total++; if (d_hex2 !== 7'b0000000) begin bad++; $display("[TB] FAIL admit_hex2 got=%b exp=0000000", d_hex2); end
   endtask

   task automatic test_wrong_then_right();
      d_p2 = 2'd0; d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      tick(); tick(); tick();
      total++; if (d_red !== 1'b1) begin bad++; $display("[TB] FAIL wrong_red got=%0b exp=1", d_red); end
      total++; if (d_green !== 1'b0) begin bad++; $display("[TB] FAIL wrong_green got=%0b exp=0", d_green); end
      d_p2 = 2'd2;
      tick(); tick();
      total++; if (d_red !== 1'b1) begin bad++; $display("[TB] FAIL wrong_hold_red got=%0b exp=1", d_red); end
      tick();
      total++; if (d_green !== 1'b1) begin bad++; $display("[TB] FAIL retry_green got=%0b exp=1", d_green); end
      total++; if (d_red !== 1'b0) begin bad++; $display("[TB] FAIL retry_red got=%0b exp=0", d_red); end
      d_exit = 1'b1;
      tick();
      d_exit = 1'b0;
      total++; if (d_free !== 4'd7) begin bad++; $display("[TB] FAIL retry_free got=%0d exp=7", d_free); end
   endtask

   task automatic test_lockout();
      int lock_err;
      d_p2 = 2'd0; d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      tick(); tick(); tick();
      tick(); tick(); tick();
      total++; if (d_lock !== 1'b0) begin bad++; $display("[TB] FAIL two_tries_lockout got=%0b exp=0", d_lock); end
      tick(); tick(); tick();
      total++; if (d_lock !== 1'b1) begin bad++; $display("[TB] FAIL lock_enter got=%0b exp=1", d_lock); end
      total++; if (d_red !== 1'b1) begin bad++; $display("[TB] FAIL lock_red got=%0b exp=1", d_red); end
      d_p2 = 2'd2; d_ent = 1'b1;
      lock_err = 0;
      for (int i = 1; i < 16; i++) begin
         d_leave = (i == 4);
         tick();
         if (d_lock !== 1'b1 || d_red !== 1'b1 || d_green !== 1'b0) lock_err++;
      end
      d_leave = 1'b0;
      total++; if (lock_err !== 0) begin bad++; $display("[TB] FAIL lock_hold got=%0d_bad_cycles exp=0", lock_err); end
      total++; if (d_free !== 4'd8) begin bad++; $display("[TB] FAIL lock_leave_free got=%0d exp=8", d_free); end
      tick();
      d_ent = 1'b0;
      total++; if (d_lock !== 1'b0) begin bad++; $display("[TB] FAIL lock_exit got=%0b exp=0", d_lock); end
      total++; if (d_red !== 1'b0) begin bad++; $display("[TB] FAIL lock_exit_red got=%0b exp=0", d_red); end
      tick(); tick(); tick(); tick();
      total++; if (d_green !== 1'b0) begin bad++; $display("[TB] FAIL lock_ignored_ent got=%0b exp=0", d_green); end
   endtask

   task automatic test_tailgate();
      d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      tick(); tick(); tick();
      total++; if (d_green !== 1'b1) begin bad++; $display("[TB] FAIL tg_right got=%0b exp=1", d_green); end
      d_ent = 1'b1; d_exit = 1'b1;
      tick();
      d_ent = 1'b0; d_exit = 1'b0; d_p2 = 2'd0;
      total++; if (d_red !== 1'b1) begin bad++; $display("[TB] FAIL tg_stop_red got=%0b exp=1", d_red); end
      total++; if (d_gate !== 1'b0) begin bad++; $display("[TB] FAIL tg_stop_gate got=%0b exp=0", d_gate); end
      total++; if (d_free !== 4'd7) begin bad++; $display("[TB] FAIL tg_free got=%0d exp=7", d_free); end
      tick(); tick(); tick(); tick();
      total++; if (d_red !== 1'b1 || d_lock !== 1'b0) begin bad++; $display("[TB] FAIL tg_stop_hold got=red%0b_lock%0b exp=red1_lock0", d_red, d_lock); end
      d_p2 = 2'd2;
      tick();
      total++; if (d_green !== 1'b1) begin bad++; $display("[TB] FAIL tg_reopen got=%0b exp=1", d_green); end
      d_exit = 1'b1;
      tick();
      d_exit = 1'b0;
      total++; if (d_free !== 4'd6) begin bad++; $display("[TB] FAIL tg_free2 got=%0d exp=6", d_free); end
      total++; if (d_hex2 !== 7'b0000010) begin bad++; $display("[TB] FAIL tg_hex2 got=%b exp=0000010", d_hex2); end
   endtask

   task automatic test_simultaneous();
      d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      tick(); tick(); tick();
      d_exit = 1'b1; d_leave = 1'b1;
      tick();
      d_exit = 1'b0; d_leave = 1'b0;
      total++; if (d_free !== 4'd6) begin bad++; $display("[TB] FAIL sim_free got=%0d exp=6", d_free); end
      total++; if (d_green !== 1'b0) begin bad++; $display("[TB] FAIL sim_green got=%0b exp=0", d_green); end
      d_ent = 1'b1;
      tick();
      d_ent = 1'b0;
      tick(); tick(); tick();
      total++; if (d_gate !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_gate got=%0b exp=1", d_gate); end
      reset_n = 1'b0; d_exit = 1'b1;
      tick();
      reset_n = 1'b1; d_exit = 1'b0;
      total++; if (d_gate !== 1'b0 || d_green !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_leds got=gate%0b_green%0b exp=0_0", d_gate, d_green); end
      total++; if (d_free !== 4'd9) begin bad++; $display("[TB] FAIL rst_mid_free got=%0d exp=9", d_free); end
      total++; if (d_hex2 !== 7'b0010000) begin bad++; $display("[TB] FAIL rst_mid_hex2 got=%b exp=0010000", d_hex2); end
   endtask

   task automatic test_capacity();
      for (int car = 0; car < 2; car++) begin
         c_ent = 1'b1;
         tick();
         c_ent = 1'b0;
         tick(); tick(); tick();
         c_exit = 1'b1;
         tick();
         c_exit = 1'b0;
      end
      total++; if (c_free !== 2'd0) begin bad++; $display("[TB] FAIL cap_free0 got=%0d exp=0", c_free); end
      total++; if (c_full !== 1'b1) begin bad++; $display("[TB] FAIL cap_full got=%0b exp=1", c_full); end
      total++; if (c_hex2 !== 7'b1000000) begin bad++; $display("[TB] FAIL cap_hex2 got=%b exp=1000000", c_hex2); end
      c_ent = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      c_ent = 1'b0;
      total++; if (c_green !== 1'b0) begin bad++; $display("[TB] FAIL cap_full_ignore got=%0b exp=0", c_green); end
      c_leave = 1'b1;
      tick();
      total++; if (c_free !== 2'd1 || c_full !== 1'b0) begin bad++; $display("[TB] FAIL cap_leave got=free%0d_full%0b exp=1_0", c_free, c_full); end
      tick(); tick();
      c_leave = 1'b0;
      total++; if (c_free !== 2'd2) begin bad++; $display("[TB] FAIL cap_sat got=%0d exp=2", c_free); end
      total++; if (c_hex2 !== 7'b0100100) begin bad++; $display("[TB] FAIL cap_sat_hex2 got=%b exp=0100100", c_hex2); end
   endtask

   initial begin
      reset_n = 1'b0;
      d_ent = 1'b0; d_exit = 1'b0; d_leave = 1'b0; d_p1 = 2'd1; d_p2 = 2'd2;
      c_ent = 1'b0; c_exit = 1'b0; c_leave = 1'b0; c_p1 = 2'd1; c_p2 = 2'd2;
      tick();
      test_reset();
      test_normal_entry();
      test_wrong_then_right();
      test_lockout();
      test_tailgate();
      test_simultaneous();
      test_capacity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
